// File: rtl/proc_io_pkg.sv
// rtl/proc_io_pkg.sv - shared widths, level-width helper and pointer type for proc_io_port
package proc_io_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int DEPTH_DEFAULT  = 8;

    // Occupancy must represent 0..DEPTH inclusive, hence one bit beyond the address.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef logic [$clog2(DEPTH_DEFAULT):0] fifo_ptr_t;

endpackage

// File: rtl/proc_io_fifo.sv
// rtl/proc_io_fifo.sv - synchronous first-word-fall-through FIFO with flush
module proc_io_fifo
    import proc_io_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = DEPTH_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        push,
    input  logic                        pop,
    input  logic [DATA_W-1:0]           wdata,
    output logic [DATA_W-1:0]           rdata,
    output logic                        full,
    output logic                        empty,
    output logic [level_w(DEPTH)-1:0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;
    assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // A full FIFO still takes a push when the head leaves on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/proc_io_port.sv
// rtl/proc_io_port.sv - paced host-to-processor feed and change-capture stream back to the host
module proc_io_port
    import proc_io_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int PACE   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic [DATA_W-1:0]           proc_data_out,
    output logic [DATA_W-1:0]           proc_data_in,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic [level_w(DEPTH)-1:0]   out_level,
    output logic                        overflow
);

    localparam int CW = (PACE > 1) ? $clog2(PACE) : 1;

    logic [CW-1:0]             cnt_q, cnt_d;
    logic [DATA_W-1:0]         pdi_q, pdi_d;
    logic [DATA_W-1:0]         last_q;
    logic                      ovf_q, ovf_d;
    logic                      in_full, in_empty, pace_fire;
    logic [DATA_W-1:0]         in_head;
    logic [level_w(DEPTH)-1:0] in_level_unused;
    logic                      out_full, out_empty, cap, out_pop;

    assign in_ready  = !in_full;
    assign pace_fire = !in_empty && (cnt_q == CW'(PACE - 1)) && !clear;

    proc_io_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_in_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (in_valid && in_ready),
        .pop   (pace_fire),
        .wdata (in_data),
        .rdata (in_head),
        .full  (in_full),
        .empty (in_empty),
        .level (in_level_unused)
    );

    // last_q follows proc_data_out every edge, including clear, so a clear edge never captures.
    assign cap       = (proc_data_out != last_q) && !clear;
    assign out_valid = !out_empty;
    assign out_pop   = out_valid && out_ready;

    proc_io_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_out_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (cap),
        .pop   (out_pop),
        .wdata (proc_data_out),
        .rdata (out_data),
        .full  (out_full),
        .empty (out_empty),
        .level (out_level)
    );

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        pdi_d = pdi_q;
        ovf_d = ovf_q;
        if (clear || in_empty || pace_fire) cnt_d = '0;
        if (pace_fire) pdi_d = in_head;
        if (clear) ovf_d = 1'b0;
        else if (cap && out_full && !out_pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            pdi_q  <= '0;
            last_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pdi_q  <= pdi_d;
            last_q <= proc_data_out;
            ovf_q  <= ovf_d;
        end
    end

    assign proc_data_in = pdi_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_proc_io_port.sv
// tb/tb_proc_io_port.sv - directed self-checking bench for proc_io_port
module tb_proc_io_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [31:0] proc_data_out;
    logic [31:0] proc_data_in;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_level;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    logic [31:0] seen[$];
    logic [31:0] prev_pdi = '0;

    proc_io_port #(.DATA_W(32), .DEPTH(8), .PACE(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear),
        .proc_data_out (proc_data_out),
        .proc_data_in  (proc_data_in),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_level     (out_level),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && proc_data_in != prev_pdi) begin
            seen.push_back(proc_data_in);
            prev_pdi = proc_data_in;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] cap_seq [7];
        logic [31:0] got;
        cap_seq = '{32'd0, 32'd5, 32'd5, 32'd7, 32'd7, 32'd7, 32'd9};

        rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; proc_data_out = '0;
        repeat (3) tick();
        check("rst_pdi",      proc_data_in, 32'h0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_level", {28'd0, out_level}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b1;
        repeat (2) tick();

        // Pacing: pushes at t0, t0+1, t0+2; words emerge at t0+4, t0+8, t0+12.
        in_valid = 1'b1; in_data = 32'hA1; tick();
        in_data = 32'hB2; tick();
        in_data = 32'hC3; tick();
        in_valid = 1'b0;
        tick();
        check("pace_early", proc_data_in, 32'h0);
        tick();
        check("pace_a1", proc_data_in, 32'hA1);
        repeat (3) tick();
        check("pace_hold_a1", proc_data_in, 32'hA1);
        tick();
        check("pace_b2", proc_data_in, 32'hB2);
        repeat (3) tick();
        check("pace_hold_b2", proc_data_in, 32'hB2);
        tick();
        check("pace_c3", proc_data_in, 32'hC3);
        repeat (10) tick();
        check("pace_hold_c3", proc_data_in, 32'hC3);

        // Change capture.
        for (int i = 0; i < 7; i++) begin
            proc_data_out = cap_seq[i];
            tick();
        end
        check("cap_level", {28'd0, out_level}, 32'd3);
        check("cap_head", out_data, 32'd5);
        check("cap_valid", {31'd0, out_valid}, 32'd1);
        check("cap_no_ovf", {31'd0, overflow}, 32'd0);
        out_ready = 1'b1;
        check("cap_pop0", out_data, 32'd5); tick();
        check("cap_pop1", out_data, 32'd7); tick();
        check("cap_pop2", out_data, 32'd9); tick();
        out_ready = 1'b0;
        check("cap_empty_valid", {31'd0, out_valid}, 32'd0);
        check("cap_empty_data", out_data, 32'd0);

        // Overflow: ten changes into an eight-deep FIFO.
        for (int i = 0; i < 10; i++) begin
            proc_data_out = 32'h100 + i;
            tick();
        end
        check("ovf_level", {28'd0, out_level}, 32'd8);
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        check("ovf_head", out_data, 32'h100);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("ovf_drain", out_data, 32'h100 + i);
            tick();
        end
        out_ready = 1'b0;
        check("ovf_drained", {28'd0, out_level}, 32'd0);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Clear with 4 input words and 3 captures pending.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data = 32'h60 + i;
            proc_data_out = (i < 3) ? 32'h400 + i : 32'h402;
            tick();
        end
        in_valid = 1'b0;
        check("clr_pre_level", {28'd0, out_level}, 32'd3);
        check("clr_pre_pdi", proc_data_in, 32'hC3);
        clear = 1'b1; proc_data_out = 32'h999;
        tick();
        clear = 1'b0;
        check("clr_in_ready", {31'd0, in_ready}, 32'd1);
        check("clr_out_valid", {31'd0, out_valid}, 32'd0);
        check("clr_out_level", {28'd0, out_level}, 32'd0);
        check("clr_overflow", {31'd0, overflow}, 32'd0);
        check("clr_pdi", proc_data_in, 32'hC3);
        repeat (12) tick();
        check("clr_pdi_hold", proc_data_in, 32'hC3);
        check("clr_no_capture", {28'd0, out_level}, 32'd0);

        // Full output FIFO with simultaneous push and pop.
        for (int i = 0; i < 8; i++) begin
            proc_data_out = 32'h200 + i;
            tick();
        end
        check("full_level", {28'd0, out_level}, 32'd8);
        check("full_no_ovf", {31'd0, overflow}, 32'd0);
        out_ready = 1'b1; proc_data_out = 32'h300;
        tick();
        check("pp_level", {28'd0, out_level}, 32'd8);
        check("pp_no_ovf", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            check("pp_drain", out_data, (i < 7) ? 32'h201 + i : 32'h300);
            tick();
        end
        out_ready = 1'b0;
        check("pp_empty", {28'd0, out_level}, 32'd0);

        // Input full: 10 pushes back to back fill it (two paced pops in between).
        seen.delete();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data = 32'h50 + i;
            tick();
        end
        check("in_full", {31'd0, in_ready}, 32'd0);
        in_data = 32'hDEAD;
        tick();
        check("in_full_hold", {31'd0, in_ready}, 32'd0);
        tick();
        in_valid = 1'b0;
        tick();
        check("in_ready_again", {31'd0, in_ready}, 32'd1);
        repeat (40) tick();
        check("in_word_count", seen.size(), 32'd10);
        for (int i = 0; i < 10; i++) begin
            got = (i < seen.size()) ? seen[i] : 32'hFFFF_FFFF;
            check("in_word", got, 32'h50 + i);
        end

        // Asynchronous reset mid-transfer.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data = 32'h70 + i;
            tick();
        end
        in_valid = 1'b0; proc_data_out = 32'h555;
        tick();
        check("mid_pre_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_pdi", proc_data_in, 32'h0);
        check("mid_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_out_data", out_data, 32'h0);
        check("mid_out_level", {28'd0, out_level}, 32'd0);
        check("mid_overflow", {31'd0, overflow}, 32'd0);
        check("mid_in_ready", {31'd0, in_ready}, 32'd1);
        proc_data_out = '0;
        tick();
        rst = 1'b1;
        repeat (10) tick();
        check("post_rst_pdi", proc_data_in, 32'h0);
        check("post_rst_valid", {31'd0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/proc_io_port.md
Name: proc_io_port

Overview:
- Peripheral-side endpoint for the SimpleProcessor data_in/data_out pair.
- Delivers host-queued words to the processor's data_in at a fixed pace.
- Captures every change on the processor's data_out into a buffered host stream with ready/valid handshakes.
- Sits between SimpleProcessor and the host or bench logic; replaces free-running stimulus and passive monitoring.

Parameters:
- DATA_W, 32, word width of all data paths.
- DEPTH, 8, entries per FIFO; power of 2, minimum 2.
- PACE, 4, cycles between successive words presented on proc_data_in; minimum 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- clear  in  1  synchronous flush, active-high.
- proc_data_out  in  DATA_W  from processor data_out.
- proc_data_in  out  DATA_W  to processor data_in.
- in_valid  in  1  host word offered.
- in_ready  out  1  input FIFO can accept a word.
- in_data  in  DATA_W  host word.
- out_valid  out  1  captured word available.
- out_ready  in  1  host accepts the captured word.
- out_data  out  DATA_W  oldest captured word.
- out_level  out  $clog2(DEPTH)+1  output FIFO occupancy.
- overflow  out  1  sticky flag: a capture was dropped.

Behaviour:
- Reset (rst=0, asynchronous): proc_data_in=0, out_valid=0, out_data=0, out_level=0, overflow=0, in_ready=1, pace counter=0, last_q=0, both FIFOs empty.
- Input path:
  - A push occurs on an edge where in_valid&&in_ready; in_ready = !in_full.
  - The pace counter holds at 0 while the input FIFO is empty; otherwise it increments each cycle.
  - At count==PACE-1 (with FIFO non-empty): pop the head, register it onto proc_data_in, reset the counter to 0.
  - Latency: a word written into an empty FIFO at edge k appears on proc_data_in after edge k+PACE.
  - Back-to-back words are spaced PACE cycles apart. PACE=1 gives one word per cycle.
  - proc_data_in holds its last value when the FIFO is empty.
- Capture path:
  - last_q registers proc_data_out every cycle.
  - If proc_data_out != last_q at an edge, push proc_data_out into the output FIFO at that edge.
  - Because last_q resets to 0, the first nonzero value after reset is captured.
  - out_valid and out_level update after the same edge.
  - out_data is first-word-fall-through: it shows the head combinationally from storage and is 0 when empty.
  - A pop occurs on an edge where out_valid&&out_ready.
- Boundaries:
  - Output full with push and no pop: drop the word, set overflow, leave the FIFO unchanged.
  - Output full with push and pop on the same edge: both succeed, level unchanged, no overflow.
  - Input full: in_ready=0; in_valid is ignored.
  - Input simultaneous push and pop: both succeed; push into an empty FIFO never bypasses the pace counter.
  - Pointers wrap modulo DEPTH. Levels span 0..DEPTH, using an extra pointer bit for the full/empty distinction.
- clear: highest priority over push and pop on its edge. It empties both FIFOs, zeroes the pace counter and overflow, and loads last_q with proc_data_out so nothing is captured on that edge. proc_data_in holds its value.
- overflow clears only on rst or clear.
- rst asserted mid-transfer: all state returns to reset values immediately, without waiting for a clock edge.

Decomposition:
- Package proc_io_pkg holds:
  - default DATA_W;
  - level-width function clog2(DEPTH)+1;
  - FIFO pointer typedef.
- One sub-module, proc_io_fifo, instantiated twice:
  - synchronous FWFT FIFO;
  - ports: push, pop, wdata, rdata, full, empty, level, clear.
- Pace counter and change detect stay in proc_io_port.

Test Plan:
- Reset check: rst=0 mid-run with 3 words queued -> all outputs 0 and in_ready=1 immediately; after release, proc_data_in stays 0 until a new push.
- Pacing: PACE=4; push 0xA1, 0xB2, 0xC3 at edges 10, 11, 12 -> proc_data_in becomes 0xA1 after edge 14, 0xB2 after edge 18, 0xC3 after edge 22, then holds 0xC3.
- Change capture: proc_data_out sequence 0, 5, 5, 7, 7, 7, 9 with out_ready=0 -> captures 5, 7, 9; out_level=3; out_data=5.
- Overflow: DEPTH=8; change proc_data_out on 10 consecutive edges, out_ready=0 -> out_level=8, first 8 values retained, overflow=1.
- Full simultaneous push/pop: FIFO full, out_ready=1 with a new change -> level stays 8, overflow stays 0, head advances by one.
- Clear: queue 4 input words and 3 captured words, pulse clear -> in_ready=1, out_valid=0, overflow=0, proc_data_in unchanged, and no capture on the clear edge.
